// File: rtl/usr_reg.sv
// Universal shift register with load/shift/rotate/clear/set and an N-step auto-shift sequencer.
// Build option: define USR_ROTATE_EN to enable rotate modes 100/101 (otherwise they act as hold).
module usr_reg #(
   parameter int unsigned       WIDTH   = 8,
   parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}},
   parameter int unsigned       CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [CNT_W-1:0] shift_cnt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done,
   output logic             dbg_state_o
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       mode_q;
   logic [2:0]       op_d;
   logic             done_q;
   logic             seq_mode_d;

   // Handshake: start is taken only in IDLE (en=1); busy is high while steps remain,
   // done pulses for one cycle after the last step or after a degenerate start.

   // In RUN the captured mode drives the datapath; live mode is ignored.
   always_comb begin
      op_d = (state_q == RUN) ? mode_q : mode;
      q_d  = q_q;
      case (op_d)
         3'b001:  q_d = d;
         3'b010:  q_d = {q_q[WIDTH-2:0], sin_r};
         3'b011:  q_d = {sin_l, q_q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
         3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
         3'b101:  q_d = {q_q[0], q_q[WIDTH-1:1]};
`endif
         3'b110:  q_d = {WIDTH{1'b0}};
         3'b111:  q_d = {WIDTH{1'b1}};
         default: q_d = q_q;
      endcase
   end

   always_comb begin
      seq_mode_d = (mode == 3'b010) || (mode == 3'b011);
`ifdef USR_ROTATE_EN
      seq_mode_d = seq_mode_d || (mode == 3'b100) || (mode == 3'b101);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= RST_VAL;
         cnt_q   <= '0;
         mode_q  <= 3'b000;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (en) begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     mode_q <= mode;
                     cnt_q  <= shift_cnt;
                     if (seq_mode_d && (shift_cnt != '0)) state_q <= RUN;
                     else                                 done_q  <= 1'b1;
                  end else begin
                     q_q <= q_d;
                  end
               end
               RUN: begin
                  q_q   <= q_d;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign q           = q_q;
   assign qn          = ~q_q;
   assign sout_l      = q_q[WIDTH-1];
   assign sout_r      = q_q[0];
   assign busy        = (state_q == RUN);
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_usr_reg.sv
// Self-checking bench for usr_reg: per-cycle comparison against a behavioural model,
// plus literal expectations at key points of the directed sequence.
module tb_usr_reg;

   localparam int unsigned W     = 8;
   localparam logic [7:0]  RSTV  = 8'hA5;
   localparam int unsigned CW    = $clog2(W + 1);

   logic          clk;
   logic          rst;
   logic          en;
   logic [2:0]    mode;
   logic [7:0]    d;
   logic          sin_l;
   logic          sin_r;
   logic          start;
   logic [CW-1:0] shift_cnt;
   logic [7:0]    q;
   logic [7:0]    qn;
   logic          sout_l;
   logic          sout_r;
   logic          busy;
   logic          done;
   logic          dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   usr_reg #(.WIDTH(W), .RST_VAL(RSTV)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
      .sin_l(sin_l), .sin_r(sin_r), .start(start), .shift_cnt(shift_cnt),
      .q(q), .qn(qn), .sout_l(sout_l), .sout_r(sout_r),
      .busy(busy), .done(done), .dbg_state_o(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef USR_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   // Behavioural model: register value, steps left in a sequence, pending done.
   typedef struct packed {
      logic [7:0]    q;
      logic          busy;
      logic          done;
      logic [CW-1:0] left;
      logic [2:0]    op;
   } model_t;

   model_t m = '{q: RSTV, busy: 1'b0, done: 1'b0, left: '0, op: 3'b000};

   function automatic logic [7:0] step(input logic [2:0] op, input logic [7:0] cur,
                                       input logic [7:0] din, input logic sl, input logic sr);
      case (op)
         3'd1: return din;
         3'd2: return (cur << 1) | {7'b0, sr};
         3'd3: return (cur >> 1) | {sl, 7'b0};
         3'd4: return ROT ? ((cur << 1) | (cur >> 7)) : cur;
         3'd5: return ROT ? ((cur >> 1) | (cur << 7)) : cur;
         3'd6: return 8'h00;
         3'd7: return 8'hFF;
         default: return cur;
      endcase
   endfunction

   function automatic bit is_shift(input logic [2:0] op);
      return (op == 3'd2) || (op == 3'd3) || (ROT && ((op == 3'd4) || (op == 3'd5)));
   endfunction

   function automatic model_t model_next(input model_t c);
      model_t n = c;
      n.done = 1'b0;
      if (rst) begin
         n = '{q: RSTV, busy: 1'b0, done: 1'b0, left: '0, op: 3'b000};
      end else if (en) begin
         if (c.busy) begin
            n.q    = step(c.op, c.q, d, sin_l, sin_r);
            n.left = c.left - 1;
            if (n.left == 0) begin
               n.busy = 1'b0;
               n.done = 1'b1;
            end
         end else if (start) begin
            if (is_shift(mode) && shift_cnt != 0) begin
               n.busy = 1'b1;
               n.left = shift_cnt;
               n.op   = mode;
            end else begin
               n.done = 1'b1;
            end
         end else begin
            n.q = step(mode, c.q, d, sin_l, sin_r);
         end
      end
      return n;
   endfunction

   always @(posedge clk) m <= model_next(m);

   // scoreboard
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_q",      q,                 m.q);
         check("m_qn",     qn,                ~m.q);
         check("m_sout_l", {7'b0, sout_l},    {7'b0, m.q[7]});
         check("m_sout_r", {7'b0, sout_r},    {7'b0, m.q[0]});
         check("m_busy",   {7'b0, busy},      {7'b0, m.busy});
         check("m_done",   {7'b0, done},      {7'b0, m.done});
         check("m_state",  {7'b0, dbg_state}, {7'b0, m.busy});
      end
   end

   // driver tasks
   task automatic drive(input logic e, input logic s, input logic [2:0] md, input logic [7:0] dv,
                        input logic sl, input logic sr, input logic [CW-1:0] cnt);
      en = e; start = s; mode = md; d = dv; sin_l = sl; sin_r = sr; shift_cnt = cnt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [2:0] md, input logic [7:0] dv, input logic sl, input logic sr);
      drive(1'b1, 1'b0, md, dv, sl, sr, '0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, '0);
      tick();
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_q", q, 8'hA5);
      check("rst_qn", qn, 8'h5A);
      check("rst_busy", {7'b0, busy}, 8'h00);
      check("rst_done", {7'b0, done}, 8'h00);

      op(3'd1, 8'h81, 1'b0, 1'b0); check("load", q, 8'h81);
      op(3'd2, 8'h00, 1'b0, 1'b0); check("shl", q, 8'h02);
      op(3'd3, 8'h00, 1'b1, 1'b0); check("shr", q, 8'h81);
      drive(1'b0, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, '0);
      tick();                      check("en_hold", q, 8'h81);
      op(3'd6, 8'h00, 1'b0, 1'b0); check("clear", q, 8'h00);
      op(3'd7, 8'h00, 1'b0, 1'b0); check("set", q, 8'hFF);

      op(3'd1, 8'h81, 1'b0, 1'b0);
      op(3'd4, 8'h00, 1'b0, 1'b0); check("rotl", q, ROT ? 8'h03 : 8'h81);
      op(3'd5, 8'h00, 1'b0, 1'b0);
      op(3'd5, 8'h00, 1'b0, 1'b0); check("rotr2", q, ROT ? 8'hC0 : 8'h81);

      // sequence of 3 left shifts with one stall; a start during RUN is ignored
      op(3'd1, 8'h01, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 4'd3);
      tick();                      check("seq_e0_busy", {7'b0, busy}, 8'h01);
      check("seq_e0_q", q, 8'h01);
      drive(1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 4'd1);
      tick();                      check("seq_e1_q", q, 8'h02);
      drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, '0);
      tick();                      check("seq_stall_q", q, 8'h02);
      check("seq_stall_busy", {7'b0, busy}, 8'h01);
      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, '0);
      tick();                      check("seq_e2_q", q, 8'h04);
      tick();                      check("seq_e3_q", q, 8'h08);
      check("seq_done", {7'b0, done}, 8'h01);
      check("seq_busy_low", {7'b0, busy}, 8'h00);

      // degenerate starts, the first accepted while done is still high
      drive(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 4'd0);
      tick();                      check("deg0_done", {7'b0, done}, 8'h01);
      check("deg0_q", q, 8'h08);
      drive(1'b1, 1'b1, 3'd1, 8'h55, 1'b0, 1'b0, 4'd3);
      tick();                      check("deg1_done", {7'b0, done}, 8'h01);
      check("deg1_q", q, 8'h08);
      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, '0);
      tick();                      check("deg_done_end", {7'b0, done}, 8'h00);
      drive(1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 4'd2);
      tick();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, '0);
      tick(); tick();              check("rot_seq_q", q, ROT ? 8'h20 : 8'h08);

      // reset after two steps of a six-step right shift
      drive(1'b1, 1'b1, 3'd3, 8'h00, 1'b1, 1'b0, 4'd6);
      tick();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, '0);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_q", q, 8'hA5);
      check("abort_busy", {7'b0, busy}, 8'h00);
      check("abort_done", {7'b0, done}, 8'h00);
      tick();                      check("abort_no_done", {7'b0, done}, 8'h00);

      // count beyond WIDTH: ten left shifts filling with ones, bounded wait for done
      drive(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 4'd10);
      tick();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, '0);
      begin
         int waited = 0;
         while (done !== 1'b1 && waited < 30) begin
            tick();
            waited++;
         end
         check("long_done_seen", {7'b0, done}, 8'h01);
         check("long_steps", 8'(waited), 8'd10);
      end
      check("long_q", q, 8'hFF);
      tick();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
